// File: rtl/uart_lite_pkg.sv
// Shared UART-lite types: parity modes, deframer FSM states and data-width limits.
package uart_lite_pkg;

   localparam int unsigned MAX_DATA_BITS = 9;
   // Counter covers data bits and stop bits.
   localparam int unsigned CNT_W = $clog2(MAX_DATA_BITS + 1);

   typedef enum logic [2:0] {
      ParNone  = 3'd0,
      ParEven  = 3'd1,
      ParOdd   = 3'd2,
      ParMark  = 3'd3,
      ParSpace = 3'd4
   } parity_mode_t;

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StParity,
      StStop,
      StBreak
   } deframer_state_t;

endpackage

// File: rtl/uart_parity.sv
// Expected parity bit for a data word under a given parity mode (shared by tx and rx).
module uart_parity
   import uart_lite_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] data_i,
   input  parity_mode_t     mode_i,
   output logic             parity_o
);

   // Even makes the total count of ones even; odd makes it odd.
   always_comb begin
      parity_o = 1'b0;
      unique case (mode_i)
         ParEven: parity_o = ^data_i;
         ParOdd:  parity_o = ~^data_i;
         ParMark: parity_o = 1'b1;
         default: parity_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/character_deframer.sv
// Async frame deframer: rebuilds characters from a per-bit stream with parity/framing checks,
// a ready/valid output register and overrun detection.
// Optional: define CHARACTER_DEFRAMER_BREAK_EN to detect line breaks (break_o).
module character_deframer
   import uart_lite_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 rx_i,
   input  logic                 valid_i,
   output logic [DATA_BITS-1:0] char_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 overrun_o,
   output logic                 break_o
);

   localparam logic [2:0]       PAR_SEL   = PARITY[2:0];
   localparam parity_mode_t     MODE      = parity_mode_t'(PAR_SEL);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

   deframer_state_t        state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   done;
   logic                   exp_par;

   logic [DATA_BITS-1:0]   char_q, char_d;
   logic                   operr_q, operr_d;
   logic                   oferr_q, oferr_d;
   logic                   valid_q, valid_d;
   logic                   overrun_q, overrun_d;

`ifdef CHARACTER_DEFRAMER_BREAK_EN
   // Every bit of the frame so far (data, parity, first stop) has been 0.
   logic                   zero_q, zero_d;
`endif

   uart_parity #(
      .WIDTH(DATA_BITS)
   ) u_parity (
      .data_i  (shift_q),
      .mode_i  (MODE),
      .parity_o(exp_par)
   );

   // Frame FSM: advances one step per valid_i strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      done    = 1'b0;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
      zero_d  = zero_q;
`endif
      if (valid_i) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_i) begin
                  state_d = StData;
                  cnt_d   = '0;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
                  zero_d  = 1'b1;
`endif
               end
            end
            StData: begin
               shift_d = {rx_i, shift_q[DATA_BITS-1:1]};
`ifdef CHARACTER_DEFRAMER_BREAK_EN
               if (rx_i) zero_d = 1'b0;
`endif
               if (cnt_q == LAST_DATA) begin
                  cnt_d   = '0;
                  state_d = (MODE == ParNone) ? StStop : StParity;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StParity: begin
               perr_d  = (rx_i != exp_par);
               state_d = StStop;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
               if (rx_i) zero_d = 1'b0;
`endif
            end
            StStop: begin
               if (!rx_i) ferr_d = 1'b1;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
               if (cnt_q == '0 && rx_i) zero_d = 1'b0;
`endif
               if (cnt_q == LAST_STOP) begin
                  state_d = StIdle;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
                  if (zero_d) state_d = StBreak;
                  else        done    = 1'b1;
`else
                  done = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StBreak: begin
               if (rx_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Output register: load on completion when empty or being drained, else flag overrun.
   always_comb begin
      char_d    = char_q;
      operr_d   = operr_q;
      oferr_d   = oferr_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && ready_i) valid_d = 1'b0;
      if (done) begin
         if (!valid_q || ready_i) begin
            char_d  = shift_q;
            operr_d = perr_q;
            oferr_d = ferr_d;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         char_q    <= '0;
         operr_q   <= 1'b0;
         oferr_q   <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
         zero_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         char_q    <= char_d;
         operr_q   <= operr_d;
         oferr_q   <= oferr_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
         zero_q    <= zero_d;
`endif
      end
   end

   assign char_o       = char_q;
   assign parity_err_o = operr_q;
   assign frame_err_o  = oferr_q;
   assign valid_o      = valid_q;
   assign overrun_o    = overrun_q;
`ifdef CHARACTER_DEFRAMER_BREAK_EN
   assign break_o      = (state_q == StBreak);
`else
   assign break_o      = 1'b0;
`endif

endmodule
